// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-bit synchroniser and bounce filter with edge pulses and change counter
module gpio_in_debounce #(
  parameter int WIDTH = 16,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o,
  output logic [7:0]       chg_cnt_o
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 16777215) begin : g_bad_stable
    $error("gpio_in_debounce: STABLE_CYCLES must be 1 to 2^24-1");
  end
  logic [WIDTH-1:0] s1, s2, acc;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] cnt_nx [WIDTH];
  // next-state: count while s2 disagrees with the accepted level, accept on the last count
  always_comb begin
    acc = '0;
    cnt_nx = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      acc[i] = (s2[i] != sw_o[i]) && (cnt[i] == LAST);
      cnt_nx[i] = (s2[i] == sw_o[i] || acc[i]) ? '0 : cnt[i] + CNT_W'(1);
    end
  end
  // synchroniser, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '{default: '0};
      sw_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      change_o <= 1'b0;
      chg_cnt_o <= '0;
    end else begin
      s1 <= sw_i;
      s2 <= s1;
      cnt <= cnt_nx;
      sw_o <= sw_o ^ acc;
      rise_o <= acc & s2;
      fall_o <= acc & ~s2;
      change_o <= |acc;
      chg_cnt_o <= chg_cnt_o + {7'b0, change_o};
    end
  end
endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: scoreboard bench for gpio_in_debounce with STABLE_CYCLES=4
module tb_gpio_in_debounce;
  localparam int SC = 4;
  localparam int LAT = SC + 2;
  typedef struct {
    int         cyc;
    logic [15:0] sw;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [7:0]  cnt;
  } evt_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] sw_i = '0;
  logic [15:0] sw_o, rise_o, fall_o;
  logic change_o;
  logic [7:0] chg_cnt_o;
  evt_t q[$];
  evt_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_sw = '0;
  logic [7:0] exp_cnt = '0;
  logic pend = 1'b0;
  logic [7:0] pend_cnt = '0;
  gpio_in_debounce #(.WIDTH(16), .STABLE_CYCLES(SC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sw_i(sw_i),
    .sw_o(sw_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .change_o(change_o),
    .chg_cnt_o(chg_cnt_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic all_zero(input string n);
    chk({n, " sw_o"}, sw_o, 16'h0);
    chk({n, " rise_o"}, rise_o, 16'h0);
    chk({n, " fall_o"}, fall_o, 16'h0);
    chk({n, " change/cnt"}, {7'b0, change_o, chg_cnt_o}, 16'h0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // drive a level that will be held long enough to be accepted and book the expected event
  task automatic set_sw(input logic [15:0] v);
    @(negedge clk);
    sw_i = v;
    if (v != exp_sw) begin
      q.push_back('{cyc + LAT, v, v & ~exp_sw, exp_sw & ~v, exp_cnt});
      exp_sw = v;
      exp_cnt++;
    end
  endtask
  task automatic do_reset(input int n, input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      all_zero({tag, " in reset"});
    end
    rst = 1'b0;
    exp_sw = '0;
    exp_cnt = '0;
    if (sw_i != 16'h0) begin
      q.push_back('{cyc + LAT, sw_i, sw_i, 16'h0, 8'h0});
      exp_sw = sw_i;
      exp_cnt = 8'h1;
    end
    @(negedge clk);
    all_zero({tag, " after release"});
  endtask
  // monitor: every change_o cycle must match the next booked event, cycle-exact
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (chg_cnt_o !== pend_cnt) begin
        errors++;
        $display("FAIL chg_cnt step: got %0d, expected %0d (cycle %0d)", chg_cnt_o, pend_cnt, cyc);
      end
      pend = 1'b0;
    end
    checks++;
    if (!change_o) begin
      if ((rise_o | fall_o) !== 16'h0) begin
        errors++;
        $display("FAIL stray pulse: rise %h fall %h with change_o=0 (cycle %0d)", rise_o, fall_o, cyc);
      end
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event: sw %h rise %h fall %h (cycle %0d)", sw_o, rise_o, fall_o, cyc);
    end else begin
      e = q.pop_front();
      if (cyc != e.cyc || sw_o !== e.sw || rise_o !== e.rise || fall_o !== e.fall || chg_cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL event: got cyc %0d sw %h rise %h fall %h cnt %0d, expected cyc %0d sw %h rise %h fall %h cnt %0d",
                 cyc, sw_o, rise_o, fall_o, chg_cnt_o, e.cyc, e.sw, e.rise, e.fall, e.cnt);
      end
      pend = 1'b1;
      pend_cnt = e.cnt + 8'h1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    sw_i = 16'hFFFF;
    do_reset(5, "reset-high");
    idle(10);
    sw_i = 16'h0;
    do_reset(5, "reset-low");
    idle(3);
    set_sw(16'h0008);
    idle(10);
    repeat (10) begin
      @(negedge clk);
      sw_i = exp_sw | 16'h0001;
      idle(2);
      @(negedge clk);
      sw_i = exp_sw;
      idle(1);
    end
    idle(8);
    chk("glitch sw_o", sw_o, 16'h0008);
    chk("glitch chg_cnt", {8'h0, chg_cnt_o}, {8'h0, exp_cnt});
    set_sw(exp_sw | 16'h0001);
    idle(10);
    set_sw(exp_sw | 16'h8002);
    idle(10);
    repeat (256) begin
      set_sw(exp_sw ^ 16'h0080);
      idle(7);
    end
    idle(10);
    chk("wrap chg_cnt", {8'h0, chg_cnt_o}, {8'h0, exp_cnt});
    @(negedge clk);
    sw_i = exp_sw | 16'h0020;
    idle(3);
    do_reset(2, "midcount");
    idle(20);
    chk("queue drained", 16'(q.size()), 16'h0);
    chk("final sw_o", sw_o, exp_sw);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
